spi_slave_ctrl: RTL and testbench

Front-end controller of the SPI slave. It synchronizes the raw SCLK/CS/MOSI pins into the system clock domain and shifts in the command byte (7-bit address + R/W). It then drives the address latch and the MISO output flop through their clock-enables, plus the data-memory write strobe. It sits between the pads and the address latch / MISO flop / data memory.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_input_sync.sv | 35 +++
 rtl/spi_slave_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_spi_slave_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave front end: FSM state encoding,
// R/W polarity of the command frame and default field widths.
package spi_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;

  localparam logic RW_READ = 1'b1;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    GET_CMD      = 3'd1,
    READ_LOAD    = 3'd2,
    READ_SHIFT   = 3'd3,
    WRITE_GET    = 3'd4,
    WRITE_COMMIT = 3'd5,
    DONE         = 3'd6
  } state_e;

endpackage

// File: rtl/spi_input_sync.sv
// Two-flop synchronizer plus a previous-value flop per pin, giving the
// synchronized level and single-cycle rise/fall detects in the clk domain.
module spi_input_sync #(
  parameter int             W       = 3,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] pin_i,
  output logic [W-1:0] sync_o,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;
  logic [W-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front end: shifts in the command frame, strobes the address
// latch, then either shifts read data out on MISO or commits one write.
//
// state        | meaning
// IDLE         | waiting for chip select
// GET_CMD      | shifting in address + R/W; holds one extra cycle for addr_le
// READ_LOAD    | capturing rdata into the shift register
// READ_SHIFT   | presenting one bit per SCLK fall on MISO
// WRITE_GET    | shifting in the write data byte
// WRITE_COMMIT | issuing the memory write strobe
// DONE         | frame complete, ignoring SCLK until CS deasserts
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk_pin,
  input  logic              cs_n_pin,
  input  logic              mosi_pin,
  input  logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_le,
  output logic [DATA_W-1:0] wdata,
  output logic              dm_we,
  output logic              miso_d,
  output logic              miso_ce,
  output logic              miso_oe
);

  logic [2:0] pin_sync;
  logic [2:0] pin_rise;
  logic [2:0] pin_fall;
  logic       unused_edges;

  // bus order {mosi, cs_n, sclk}; cs_n resets to the inactive level
  spi_input_sync #(
    .W       (3),
    .RST_VAL (3'b010)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin_i  ({mosi_pin, cs_n_pin, sclk_pin}),
    .sync_o (pin_sync),
    .rise_o (pin_rise),
    .fall_o (pin_fall)
  );

  logic sclk_rise;
  logic sclk_fall;
  logic cs_active;
  logic mosi_sync;

  assign sclk_rise    = pin_rise[0];
  assign sclk_fall    = pin_fall[0];
  assign cs_active    = ~pin_sync[1];
  assign mosi_sync    = pin_sync[2];
  assign unused_edges = ^{pin_rise[2:1], pin_fall[2:1]};

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] shift_in;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              addr_le_q, addr_le_d;
  logic              dm_we_q, dm_we_d;
  logic              miso_d_q, miso_d_d;
  logic              miso_ce_q, miso_ce_d;
  logic              miso_oe_q, miso_oe_d;

  assign shift_in = {shift_q[DATA_W-2:0], mosi_sync};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    addr_le_d = 1'b0;
    dm_we_d   = 1'b0;
    miso_d_d  = miso_d_q;
    miso_ce_d = 1'b0;
    miso_oe_d = 1'b0;

    // CS release wins over everything, including a frame-completing edge
    if (!cs_active) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = GET_CMD;
          cnt_d   = 3'd0;
        end
        GET_CMD: begin
          // addr_le is high this cycle; shift_q[0] still holds the R/W bit
          if (addr_le_q) begin
            state_d = (shift_q[0] == RW_READ) ? READ_LOAD : WRITE_GET;
            cnt_d   = 3'd0;
          end else if (sclk_rise) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              addr_le_d = 1'b1;
              addr_d    = shift_in[ADDR_W:1];
            end
          end
        end
        READ_LOAD: begin
          shift_d = rdata;
          cnt_d   = 3'd0;
          state_d = READ_SHIFT;
        end
        READ_SHIFT: begin
          // registered oe stays up through the cycle carrying the last miso_ce
          miso_oe_d = 1'b1;
          if (sclk_fall) begin
            miso_d_d  = shift_q[DATA_W-1];
            miso_ce_d = 1'b1;
            shift_d   = shift_q << 1;
            cnt_d     = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = DONE;
          end
        end
        WRITE_GET: begin
          if (sclk_rise) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              wdata_d = shift_in;
              state_d = WRITE_COMMIT;
            end
          end
        end
        WRITE_COMMIT: begin
          dm_we_d = 1'b1;
          state_d = DONE;
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      shift_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      addr_le_q <= 1'b0;
      dm_we_q   <= 1'b0;
      miso_d_q  <= 1'b0;
      miso_ce_q <= 1'b0;
      miso_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      addr_le_q <= addr_le_d;
      dm_we_q   <= dm_we_d;
      miso_d_q  <= miso_d_d;
      miso_ce_q <= miso_ce_d;
      miso_oe_q <= miso_oe_d;
    end
  end

  assign addr    = addr_q;
  assign addr_le = addr_le_q;
  assign wdata   = wdata_q;
  assign dm_we   = dm_we_q;
  assign miso_d  = miso_d_q;
  assign miso_ce = miso_ce_q;
  assign miso_oe = miso_oe_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: table of full frames plus hand-built
// abort, reset and back-to-back sequences.
module tb_spi_slave_ctrl;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk_pin, cs_n_pin, mosi_pin;
  logic [7:0] rdata = 8'h00;
  logic [6:0] addr;
  logic       addr_le;
  logic [7:0] wdata;
  logic       dm_we, miso_d, miso_ce, miso_oe;

  spi_slave_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk_pin (sclk_pin),
    .cs_n_pin (cs_n_pin),
    .mosi_pin (mosi_pin),
    .rdata    (rdata),
    .addr     (addr),
    .addr_le  (addr_le),
    .wdata    (wdata),
    .dm_we    (dm_we),
    .miso_d   (miso_d),
    .miso_ce  (miso_ce),
    .miso_oe  (miso_oe)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory model: requested word appears only on the cycle after addr_le
  logic [7:0] rd_val = 8'h00;
  always @(posedge clk) rdata <= addr_le ? rd_val : 8'h3C;

  logic [7:0] le_q[$];
  logic [7:0] we_q[$];
  int         n_ce, n_overlap, le_cyc, we_cyc;
  logic [7:0] miso_byte;
  logic       oe_bad;

  always @(negedge clk) begin
    if (rst_n) begin
      if (addr_le) begin le_q.push_back({1'b0, addr}); le_cyc = cyc; end
      if (dm_we)   begin we_q.push_back(wdata); we_cyc = cyc; end
      if (miso_ce) begin
        miso_byte = {miso_byte[6:0], miso_d};
        n_ce++;
        if (!miso_oe) oe_bad = 1'b1;
      end
      if ((32'(addr_le) + 32'(dm_we) + 32'(miso_ce)) > 1) n_overlap++;
    end
  end

  task automatic clear_mon();
    le_q.delete();
    we_q.delete();
    n_ce = 0; n_overlap = 0; le_cyc = -1; we_cyc = -1;
    miso_byte = 8'h00; oe_bad = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int last_rise;

  task automatic spi_bit(input logic b);
    mosi_pin = b;
    repeat (6) @(negedge clk);
    sclk_pin  = 1'b1;
    last_rise = cyc;
    repeat (6) @(negedge clk);
    sclk_pin = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] data;
    logic [6:0] exp_addr;
    logic       is_read;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    int cmd_rise, dat_rise;
    clear_mon();
    rd_val   = v.data;
    cs_n_pin = 1'b0;
    repeat (6) @(negedge clk);
    send_byte(v.cmd);
    cmd_rise = last_rise;
    send_byte(v.is_read ? 8'h00 : v.data);
    dat_rise = last_rise;
    repeat (4) @(negedge clk);
    chk("state_done", 32'(dut.state_q), 32'(DONE));
    chk("addr_le_count", le_q.size(), 1);
    if (le_q.size() == 1) chk("addr_value", le_q[0], {1'b0, v.exp_addr});
    chk("addr_le_latency", le_cyc - cmd_rise, 3);
    chk("overlap", n_overlap, 0);
    if (v.is_read) begin
      chk("miso_ce_count", n_ce, 8);
      chk("miso_byte", miso_byte, v.exp_byte);
      chk("miso_oe_held", oe_bad, 0);
      chk("read_no_we", we_q.size(), 0);
    end else begin
      chk("dm_we_count", we_q.size(), 1);
      if (we_q.size() == 1) chk("wdata_value", we_q[0], v.exp_byte);
      chk("dm_we_latency", we_cyc - dat_rise, 4);
      chk("write_no_ce", n_ce, 0);
    end
    cs_n_pin = 1'b1;
    repeat (6) @(negedge clk);
    chk("state_idle_after_cs", 32'(dut.state_q), 32'(IDLE));
    chk("miso_oe_low_after", miso_oe, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h54, 8'hC3, 7'h2A, 1'b0, 8'hC3};
    vecs[1] = '{8'h55, 8'hA5, 7'h2A, 1'b1, 8'hA5};
    vecs[2] = '{8'h02, 8'h7E, 7'h01, 1'b0, 8'h7E};
    vecs[3] = '{8'hFF, 8'h5A, 7'h7F, 1'b1, 8'h5A};
    vecs[4] = '{8'h80, 8'h01, 7'h40, 1'b0, 8'h01};
    vecs[5] = '{8'h01, 8'h80, 7'h00, 1'b1, 8'h80};

    rst_n = 1'b0; sclk_pin = 1'b0; cs_n_pin = 1'b1; mosi_pin = 1'b0;
    clear_mon();
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_outs", {addr_le, dm_we, miso_ce, miso_oe, miso_d}, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // aborted command after 5 bits, then a clean write frame 0x02
    clear_mon();
    cs_n_pin = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 5; i++) spi_bit(1'b1);
    repeat (6) @(negedge clk);
    cs_n_pin = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_le", le_q.size(), 0);
    chk("abort_state", 32'(dut.state_q), 32'(IDLE));
    run_vec(vecs[2]);

    // CS release detected in the same cycle as the 16th SCLK rise
    clear_mon();
    cs_n_pin = 1'b0;
    repeat (6) @(negedge clk);
    send_byte(8'h54);
    for (int i = 0; i < 7; i++) spi_bit(1'b1);
    mosi_pin = 1'b1;
    repeat (6) @(negedge clk);
    sclk_pin = 1'b1;
    cs_n_pin = 1'b1;
    repeat (10) @(negedge clk);
    sclk_pin = 1'b0;
    repeat (6) @(negedge clk);
    chk("boundary_le", le_q.size(), 1);
    chk("boundary_no_we", we_q.size(), 0);
    chk("boundary_state", 32'(dut.state_q), 32'(IDLE));

    // back-to-back writes with a 2-cycle CS gap
    clear_mon();
    cs_n_pin = 1'b0;
    repeat (6) @(negedge clk);
    send_byte(8'h54);
    send_byte(8'h11);
    repeat (6) @(negedge clk);
    cs_n_pin = 1'b1;
    repeat (2) @(negedge clk);
    cs_n_pin = 1'b0;
    repeat (6) @(negedge clk);
    send_byte(8'h0A);
    send_byte(8'hEE);
    repeat (6) @(negedge clk);
    cs_n_pin = 1'b1;
    repeat (6) @(negedge clk);
    chk("b2b_le_count", le_q.size(), 2);
    chk("b2b_we_count", we_q.size(), 2);
    if (le_q.size() == 2) begin
      chk("b2b_addr0", le_q[0], 8'h2A);
      chk("b2b_addr1", le_q[1], 8'h05);
    end
    if (we_q.size() == 2) begin
      chk("b2b_wdata0", we_q[0], 8'h11);
      chk("b2b_wdata1", we_q[1], 8'hEE);
    end

    // reset asserted in the middle of the write data phase
    clear_mon();
    cs_n_pin = 1'b0;
    repeat (6) @(negedge clk);
    send_byte(8'h54);
    for (int i = 0; i < 3; i++) spi_bit(1'b1);
    repeat (2) @(negedge clk);
    chk("mid_state_wget", 32'(dut.state_q), 32'(WRITE_GET));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("mid_rst_outs", {addr_le, dm_we, miso_ce, miso_oe, miso_d}, 0);
    chk("mid_rst_addr", addr, 0);
    chk("mid_rst_wdata", wdata, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    for (int i = 0; i < 5; i++) spi_bit(1'b1);
    repeat (6) @(negedge clk);
    cs_n_pin = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_no_we", we_q.size(), 0);
    chk("post_rst_no_le", le_q.size(), 0);
    chk("post_rst_state", 32'(dut.state_q), 32'(IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
